icetap_capture_ctrl: RTL and testbench

Capture sequencer for the icetap logic analyzer, running entirely in the `src_clk` domain. It runs the record state machine and the circular write pointer into the capture BRAM. It also produces the start, trigger and stop addresses and a read pointer for scan-out. It sits between the mask/compare logic, which supplies per-sample `store` and `trigger` qualifiers, and the dual-port sample RAM. Configuration and command inputs arrive already synchronized into `src_clk`.

---
 rtl/icetap_capture_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_icetap_capture_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icetap_capture_ctrl.sv
// Purpose    : icetap capture sequencer. It runs the record FSM and the circular write pointer
//              into the sample RAM, and tracks the start/trigger/stop addresses and the scan-out
//              read pointer.
// Latency    : a qualifying sample is presented on the RAM write port one cycle after it is
//              sampled. The read pointer follows its request by one cycle.
// Backpressure: none. The RAM accepts every write. store/trigger qualify samples but never stall.
//
// Ports:
//   src_clk, src_reset_         - sole clock; async active-low reset
//   start, abort                - single-cycle command pulses (abort wins)
//   post_trigger_cnt            - samples to keep after the trigger (latched on start)
//   signals_in, store, trigger  - sample and its qualifiers from the mask/compare logic
//   ram_wr_ena/addr/data        - registered RAM write port
//   state                       - 0 IDLE, 1 PRE_TRIG, 2 POST_TRIG, 3 DONE
//   start_addr, trigger_addr,
//   stop_addr                   - oldest sample, trigger sample, last written sample
//   read_req_first/next         - scan-out pointer control (first wins)
//   ram_rd_addr                 - registered RAM read address
module icetap_capture_ctrl #(
  parameter int NR_SIGNALS    = 16,
  parameter int RECORD_DEPTH  = 256,
  parameter int RAM_ADDR_BITS = $clog2(RECORD_DEPTH)
) (
  input  logic                     src_clk,
  input  logic                     src_reset_,
  input  logic                     start,
  input  logic                     abort,
  input  logic [RAM_ADDR_BITS-1:0] post_trigger_cnt,
  input  logic [NR_SIGNALS-1:0]    signals_in,
  input  logic                     store,
  input  logic                     trigger,
  output logic                     ram_wr_ena,
  output logic [RAM_ADDR_BITS-1:0] ram_wr_addr,
  output logic [NR_SIGNALS-1:0]    ram_wr_data,
  output logic [1:0]               state,
  output logic [RAM_ADDR_BITS-1:0] start_addr,
  output logic [RAM_ADDR_BITS-1:0] trigger_addr,
  output logic [RAM_ADDR_BITS-1:0] stop_addr,
  input  logic                     read_req_first,
  input  logic                     read_req_next,
  output logic [RAM_ADDR_BITS-1:0] ram_rd_addr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int FILL_BITS = RAM_ADDR_BITS + 1;
  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE  = RAM_ADDR_BITS'(1);
  localparam logic [FILL_BITS-1:0]     FILL_ONE  = FILL_BITS'(1);
  localparam logic [FILL_BITS-1:0]     FILL_FULL = FILL_BITS'(RECORD_DEPTH);

  state_e                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [FILL_BITS-1:0]     fill_q, fill_d;
  logic [RAM_ADDR_BITS-1:0] post_cnt_q, post_cnt_d;
  logic [RAM_ADDR_BITS-1:0] post_lim_q, post_lim_d;
  logic [RAM_ADDR_BITS-1:0] start_addr_q, start_addr_d;
  logic [RAM_ADDR_BITS-1:0] trigger_addr_q, trigger_addr_d;
  logic [RAM_ADDR_BITS-1:0] stop_addr_q, stop_addr_d;
  logic                     wr_ena_q, wr_ena_d;
  logic [RAM_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [NR_SIGNALS-1:0]    wr_data_q, wr_data_d;
  logic [RAM_ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                     do_write;

  // Next-state logic. abort has priority over start. A command cycle never
  // writes: the qualifiers of that sample are dropped.
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    fill_d         = fill_q;
    post_cnt_d     = post_cnt_q;
    post_lim_d     = post_lim_q;
    start_addr_d   = start_addr_q;
    trigger_addr_d = trigger_addr_q;
    stop_addr_d    = stop_addr_q;
    wr_ena_d       = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    rd_addr_d      = rd_addr_q;
    do_write       = 1'b0;

    if (abort) begin
      // Addresses and pointers are kept so a partial capture can still be read.
      state_d = ST_IDLE;
    end else if (start) begin
      state_d        = ST_PRE;
      wr_ptr_d       = '0;
      fill_d         = '0;
      post_cnt_d     = '0;
      post_lim_d     = post_trigger_cnt;
      start_addr_d   = '0;
      trigger_addr_d = '0;
      stop_addr_d    = '0;
    end else begin
      unique case (state_q)
        ST_PRE:  do_write = store | trigger;  // the trigger sample is always kept
        ST_POST: do_write = store;
        default: do_write = 1'b0;
      endcase

      if (do_write) begin
        wr_ena_d    = 1'b1;
        wr_addr_d   = wr_ptr_q;
        wr_data_d   = signals_in;
        stop_addr_d = wr_ptr_q;
        wr_ptr_d    = wr_ptr_q + ADDR_ONE;

        // When the ring is full, the oldest sample is overwritten, so the
        // start of valid data moves with the write pointer.
        if (fill_q == FILL_FULL) begin
          start_addr_d = start_addr_q + ADDR_ONE;
        end else begin
          fill_d = fill_q + FILL_ONE;
        end

        if (state_q == ST_PRE && trigger) begin
          trigger_addr_d = wr_ptr_q;
          state_d        = (post_lim_q == '0) ? ST_DONE : ST_POST;
        end else if (state_q == ST_POST) begin
          // post_lim_q is at most RECORD_DEPTH-1, so the trigger sample is
          // never overwritten and post_cnt never wraps before DONE.
          post_cnt_d = post_cnt_q + ADDR_ONE;
          if (post_cnt_d == post_lim_q) begin
            state_d = ST_DONE;
          end
        end
      end
    end

    // The scan-out pointer works in every state. read_req_first wins over read_req_next.
    if (read_req_first) begin
      rd_addr_d = start_addr_q;
    end else if (read_req_next) begin
      rd_addr_d = rd_addr_q + ADDR_ONE;
    end
  end

  always_ff @(posedge src_clk or negedge src_reset_) begin
    if (!src_reset_) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      fill_q         <= '0;
      post_cnt_q     <= '0;
      post_lim_q     <= '0;
      start_addr_q   <= '0;
      trigger_addr_q <= '0;
      stop_addr_q    <= '0;
      wr_ena_q       <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      rd_addr_q      <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      fill_q         <= fill_d;
      post_cnt_q     <= post_cnt_d;
      post_lim_q     <= post_lim_d;
      start_addr_q   <= start_addr_d;
      trigger_addr_q <= trigger_addr_d;
      stop_addr_q    <= stop_addr_d;
      wr_ena_q       <= wr_ena_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      rd_addr_q      <= rd_addr_d;
    end
  end

  assign state        = state_q;
  assign ram_wr_ena   = wr_ena_q;
  assign ram_wr_addr  = wr_addr_q;
  assign ram_wr_data  = wr_data_q;
  assign start_addr   = start_addr_q;
  assign trigger_addr = trigger_addr_q;
  assign stop_addr    = stop_addr_q;
  assign ram_rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// Purpose    : self-checking bench for icetap_capture_ctrl (depth 16, 8-bit samples).
// Latency    : compares the outputs against a write-count based reference every cycle.
// Backpressure: not applicable. Inputs are driven freely.
module tb_icetap_capture_ctrl;
  localparam int NS = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          src_clk = 1'b0;
  logic          src_reset_ = 1'b1;
  logic          start = 1'b0, abort = 1'b0, store = 1'b0, trigger = 1'b0;
  logic          read_req_first = 1'b0, read_req_next = 1'b0;
  logic [AW-1:0] post_trigger_cnt = '0;
  logic [NS-1:0] signals_in = '0;
  logic          ram_wr_ena;
  logic [AW-1:0] ram_wr_addr, start_addr, trigger_addr, stop_addr, ram_rd_addr;
  logic [NS-1:0] ram_wr_data;
  logic [1:0]    state;

  icetap_capture_ctrl #(.NR_SIGNALS(NS), .RECORD_DEPTH(D)) dut (
    .src_clk(src_clk), .src_reset_(src_reset_), .start(start), .abort(abort),
    .post_trigger_cnt(post_trigger_cnt), .signals_in(signals_in), .store(store),
    .trigger(trigger), .ram_wr_ena(ram_wr_ena), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .state(state), .start_addr(start_addr),
    .trigger_addr(trigger_addr), .stop_addr(stop_addr),
    .read_req_first(read_req_first), .read_req_next(read_req_next),
    .ram_rd_addr(ram_rd_addr)
  );

  always #5 src_clk = ~src_clk;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. A capture is described by how many samples were written
  // since start (m_nw), at which write the trigger landed (m_trig_w) and how
  // many post-trigger writes were made. Every address is derived from these counts.
  int m_state = 0, m_nw = 0, m_trig_w = 0, m_post = 0, m_lim = 0, m_rd = 0;
  int m_wr_vld = 0, m_wr_addr = 0, m_wr_data = 0;

  function automatic int m_start_addr();
    return (m_nw > D) ? ((m_nw - D) % D) : 0;
  endfunction
  function automatic int m_stop_addr();
    return (m_nw == 0) ? 0 : ((m_nw - 1) % D);
  endfunction
  function automatic int m_trig_addr();
    return m_trig_w % D;
  endfunction

  always @(posedge src_clk or negedge src_reset_) begin
    if (!src_reset_) begin
      m_state = 0; m_nw = 0; m_trig_w = 0; m_post = 0; m_lim = 0; m_rd = 0;
      m_wr_vld = 0; m_wr_addr = 0; m_wr_data = 0;
    end else begin
      if (read_req_first)     m_rd = m_start_addr();
      else if (read_req_next) m_rd = (m_rd + 1) % D;
      m_wr_vld = 0;
      if (abort) begin
        m_state = 0;
      end else if (start) begin
        m_state = 1; m_nw = 0; m_trig_w = 0; m_post = 0; m_lim = int'(post_trigger_cnt);
      end else if ((m_state == 1 && (store || trigger)) || (m_state == 2 && store)) begin
        m_wr_vld  = 1;
        m_wr_addr = m_nw % D;
        m_wr_data = int'(signals_in);
        if (m_state == 1 && trigger) begin
          m_trig_w = m_nw;
          m_state  = (m_lim == 0) ? 3 : 2;
        end else if (m_state == 2) begin
          m_post++;
          if (m_post == m_lim) m_state = 3;
        end
        m_nw++;
      end
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge src_clk) begin
    chk("state", int'(state), m_state);
    chk("start_addr", int'(start_addr), m_start_addr());
    chk("trigger_addr", int'(trigger_addr), m_trig_addr());
    chk("stop_addr", int'(stop_addr), m_stop_addr());
    chk("ram_rd_addr", int'(ram_rd_addr), m_rd);
    chk("ram_wr_ena", int'(ram_wr_ena), m_wr_vld);
    if (m_wr_vld != 0) begin
      chk("ram_wr_addr", int'(ram_wr_addr), m_wr_addr);
      chk("ram_wr_data", int'(ram_wr_data), m_wr_data);
    end
  end

  task automatic tick();
    @(negedge src_clk);
    #1;
    if (ram_wr_ena) pulses++;
  endtask

  task automatic clr();
    start = 0; abort = 0; store = 0; trigger = 0;
    read_req_first = 0; read_req_next = 0;
  endtask

  task automatic arm(input int ptc);
    post_trigger_cnt = AW'(ptc);
    start = 1;
    tick();
    start = 0;
  endtask

  int post_cycles;

  initial begin
    #1 src_reset_ = 0;
    repeat (3) @(negedge src_clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_stop", int'(stop_addr), 0);
    chk("rst_wr_ena", int'(ram_wr_ena), 0);
    chk("rst_rd", int'(ram_rd_addr), 0);
    src_reset_ = 1;
    tick();

    // No wrap: trigger on the 5th sample, 3 post samples.
    clr(); arm(3);
    chk("s1_armed", int'(state), 1);
    pulses = 0; store = 1;
    for (int i = 0; i < 8; i++) begin
      trigger = (i == 4); signals_in = NS'($urandom); tick();
    end
    trigger = 0;
    chk("s1_state", int'(state), 3);
    chk("s1_trig", int'(trigger_addr), 4);
    chk("s1_stop", int'(stop_addr), 7);
    chk("s1_start", int'(start_addr), 0);
    repeat (3) tick();
    chk("s1_pulses", pulses, 8);

    // Wrap: trigger on the 40th sample, 5 post samples.
    clr(); arm(5);
    store = 1;
    for (int i = 0; i < 45; i++) begin
      trigger = (i == 39); signals_in = NS'($urandom); tick();
    end
    clr();
    chk("s2_state", int'(state), 3);
    chk("s2_trig", int'(trigger_addr), 7);
    chk("s2_stop", int'(stop_addr), 12);
    chk("s2_start", int'(start_addr), 13);
    read_req_first = 1; tick(); read_req_first = 0;
    chk("s2_rd_first", int'(ram_rd_addr), 13);
    read_req_next = 1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("s2_rd_walk", int'(ram_rd_addr), (13 + k) % 16);
    end
    read_req_next = 0;

    // Zero post count, store low: the trigger sample alone is written.
    clr(); arm(0);
    pulses = 0;
    repeat (3) tick();
    chk("s3_pre", int'(state), 1);
    trigger = 1; signals_in = 8'hA5; tick(); trigger = 0;
    chk("s3_state", int'(state), 3);
    chk("s3_wr_ena", int'(ram_wr_ena), 1);
    chk("s3_wr_addr", int'(ram_wr_addr), 0);
    chk("s3_wr_data", int'(ram_wr_data), 8'hA5);
    chk("s3_stop", int'(stop_addr), 0);
    chk("s3_trig", int'(trigger_addr), 0);
    repeat (2) tick();
    chk("s3_pulses", pulses, 1);

    // Gated store after the trigger: store is 0,1,0,1,... so POST_TRIG spans 8 cycles.
    clr(); arm(4);
    store = 1;
    for (int i = 0; i < 3; i++) begin
      trigger = (i == 2); signals_in = NS'($urandom); tick();
    end
    trigger = 0;
    chk("s4_trig", int'(trigger_addr), 2);
    pulses = 0;
    post_cycles = (state == 2'd2) ? 1 : 0;
    for (int j = 0; j < 12; j++) begin
      store = (j % 2 == 1); signals_in = NS'($urandom); tick();
      if (state == 2'd2) post_cycles++;
    end
    chk("s4_post_cycles", post_cycles, 8);
    chk("s4_post_pulses", pulses, 4);
    chk("s4_stop", int'(stop_addr), 6);
    chk("s4_state", int'(state), 3);

    // Abort in POST_TRIG, then start+abort together, then a clean start.
    clr(); arm(6);
    store = 1;
    for (int i = 0; i < 4; i++) begin
      trigger = (i == 1); signals_in = NS'($urandom); tick();
    end
    trigger = 0;
    chk("s5_in_post", int'(state), 2);
    abort = 1; tick(); abort = 0;
    chk("s5_abort_state", int'(state), 0);
    chk("s5_abort_ena", int'(ram_wr_ena), 0);
    chk("s5_abort_trig", int'(trigger_addr), 1);
    chk("s5_abort_stop", int'(stop_addr), 3);
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    chk("s5_both_state", int'(state), 0);
    chk("s5_both_stop", int'(stop_addr), 3);
    start = 1; tick(); start = 0;
    chk("s5_restart_state", int'(state), 1);
    chk("s5_restart_stop", int'(stop_addr), 0);
    chk("s5_restart_trig", int'(trigger_addr), 0);

    // Reset mid-capture, checked before the next rising edge.
    signals_in = 8'h3C;
    repeat (10) tick();
    chk("s6_stop_before", int'(stop_addr), 9);
    #2 src_reset_ = 0;
    #1;
    chk("s6_state", int'(state), 0);
    chk("s6_stop", int'(stop_addr), 0);
    chk("s6_wr_ena", int'(ram_wr_ena), 0);
    chk("s6_wr_addr", int'(ram_wr_addr), 0);
    chk("s6_wr_data", int'(ram_wr_data), 0);
    chk("s6_rd", int'(ram_rd_addr), 0);
    clr();
    tick();
    src_reset_ = 1;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      start            = ($urandom % 40) == 0;
      abort            = ($urandom % 80) == 0;
      trigger          = ($urandom % 8) == 0;
      store            = ($urandom % 2) == 0;
      read_req_first   = ($urandom % 20) == 0;
      read_req_next    = ($urandom % 3) == 0;
      post_trigger_cnt = AW'($urandom);
      signals_in       = NS'($urandom);
      tick();
    end
    clr();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
